// File: rtl/audio_note_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : audio_note_ctrl
// Brief    : Latches note/tempo words and plays a timed square-wave note,
//            pulsing note_done at the end to release the stalled PC.
// Revision : 1.0
// ============================================================================
module audio_note_ctrl #(
  parameter int TICK_DIV  = 50000,
  parameter int HALF_BASE = 64,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              audioreg,
  input  logic              audioact,
  input  logic              s_cont,
  input  logic [DATA_W-1:0] data_in,
  output logic              note_done,
  output logic              busy,
  output logic              speaker
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Half-period counter is at least 9 bits, widened so pitch 1 never wraps.
  localparam int HALF_W = ($clog2(15 * HALF_BASE + 1) > 9) ? $clog2(15 * HALF_BASE + 1) : 9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   note_q, note_d;
  logic [7:0]          tempo_q, tempo_d;
  logic [3:0]          pitch_q, pitch_d;
  logic [3:0]          rem_q, rem_d;
  logic [7:0]          beat_q, beat_d;
  logic [7:0]          bcnt_q, bcnt_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [HALF_W-1:0]   half_q, half_d;
  logic                spk_q, spk_d;

  logic [HALF_W-1:0]   half_per;
  logic                play_req;
  logic                tick_end;
  logic                beat_end;

  assign play_req = audioact && !s_cont;
  assign tick_end = (tick_q == TICK_W'(TICK_DIV - 1));
  assign beat_end = (bcnt_q == (beat_q - 8'd1));
  assign half_per = HALF_W'((16 - int'(pitch_q)) * HALF_BASE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      note_q  <= '0;
      tempo_q <= 8'd1;
      pitch_q <= '0;
      rem_q   <= '0;
      beat_q  <= 8'd1;
      bcnt_q  <= '0;
      tick_q  <= '0;
      half_q  <= '0;
      spk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      tempo_q <= tempo_d;
      pitch_q <= pitch_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
      bcnt_q  <= bcnt_d;
      tick_q  <= tick_d;
      half_q  <= half_d;
      spk_q   <= spk_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    note_d    = note_q;
    tempo_d   = tempo_q;
    pitch_d   = pitch_q;
    rem_d     = rem_q;
    beat_d    = beat_q;
    bcnt_d    = bcnt_q;
    tick_d    = tick_q;
    half_d    = half_q;
    spk_d     = spk_q;
    note_done = 1'b0;
    busy      = 1'b0;
    speaker   = 1'b0;

    if (audioreg) begin
      note_d = data_in;
    end
    // A zero tempo would make the beat counter never terminate.
    if (audioact && s_cont) begin
      tempo_d = (data_in == '0) ? 8'd1 : 8'(data_in);
    end

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        bcnt_d = '0;
        half_d = '0;
        spk_d  = 1'b0;
        if (play_req) begin
          pitch_d = note_q[7:4];
          rem_d   = note_q[3:0];
          beat_d  = tempo_q;
          state_d = (note_q[3:0] == 4'd0) ? S_DONE : S_PLAY;
        end
      end

      S_PLAY: begin
        busy    = 1'b1;
        speaker = spk_q;
        tick_d  = tick_end ? '0 : tick_q + 1'b1;
        if (tick_end) begin
          bcnt_d = beat_end ? 8'd0 : bcnt_q + 8'd1;
          if (beat_end) begin
            rem_d = rem_q - 4'd1;
            if (rem_q == 4'd1) begin
              state_d = S_DONE;
            end
          end
        end
        if (pitch_q != 4'd0) begin
          if (half_q == (half_per - 1'b1)) begin
            half_d = '0;
            spk_d  = ~spk_q;
          end else begin
            half_d = half_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        busy      = 1'b1;
        note_done = 1'b1;
        spk_d     = 1'b0;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_note_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_note_ctrl
// Brief    : Directed scoreboard bench for audio_note_ctrl (TICK_DIV=4, HALF_BASE=2).
// Revision : 1.0
// ============================================================================
module tb_audio_note_ctrl;

  logic       clk;
  logic       reset;
  logic       audioreg;
  logic       audioact;
  logic       s_cont;
  logic [7:0] data_in;
  logic       note_done;
  logic       busy;
  logic       speaker;

  typedef struct {
    int done_cyc;
    int rises;
  } exp_t;

  exp_t exp_q[$];
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   rises   = 0;
  logic prev_spk = 1'b0;

  audio_note_ctrl #(
    .TICK_DIV (4),
    .HALF_BASE(2),
    .DATA_W   (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .audioreg (audioreg),
    .audioact (audioact),
    .s_cont   (s_cont),
    .data_in  (data_in),
    .note_done(note_done),
    .busy     (busy),
    .speaker  (speaker)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts speaker rising edges per note and checks each done pulse.
  always @(negedge clk) begin
    if (reset) begin
      rises = 0;
    end else begin
      if (speaker && !prev_spk) rises++;
      if (note_done) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_done at cyc=%0d, no note outstanding", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (cyc != e.done_cyc) begin
            n_bad++;
            $display("FAIL done_time got cyc=%0d want cyc=%0d", cyc, e.done_cyc);
          end
          n_cmp++;
          if (rises != e.rises) begin
            n_bad++;
            $display("FAIL speaker_rises got %0d want %0d", rises, e.rises);
          end
        end
        rises = 0;
      end
    end
    prev_spk = speaker;
  end

  task automatic check(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %0b want %0b", name, got, want);
    end
  endtask

  task automatic load_note(input logic [7:0] b);
    @(negedge clk);
    audioreg = 1'b1;
    data_in  = b;
    @(negedge clk);
    audioreg = 1'b0;
  endtask

  task automatic load_tempo(input logic [7:0] b);
    @(negedge clk);
    audioact = 1'b1;
    s_cont   = 1'b1;
    data_in  = b;
    @(negedge clk);
    audioact = 1'b0;
    s_cont   = 1'b0;
  endtask

  // Issues a one-cycle play request; play_cycles/exp_rises are hand-computed.
  task automatic play(input bit expect_done, input int play_cycles, input int exp_rises);
    @(negedge clk);
    audioact = 1'b1;
    s_cont   = 1'b0;
    if (expect_done) exp_q.push_back('{cyc + 1 + play_cycles, exp_rises});
    @(negedge clk);
    audioact = 1'b0;
    check("busy_after_request", busy, 1'b1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (busy) begin
      n_bad++;
      $display("FAIL idle_timeout busy=%0b want 0 after %0d cycles", busy, k);
    end
  endtask

  initial begin
    int c0;
    reset    = 1'b1;
    audioreg = 1'b0;
    audioact = 1'b0;
    s_cont   = 1'b0;
    data_in  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_note_done", note_done, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_speaker", speaker, 1'b0);
    reset = 1'b0;

    // Pitch F, dur 2, tempo 3: 24 play cycles, half period 2 -> 6 rises.
    load_note(8'hF2);
    load_tempo(8'h03);
    play(1'b1, 24, 6);
    wait_idle();

    // Tempo 0 behaves as 1; pitch 1 half period 30 never toggles in 4 cycles.
    load_tempo(8'h00);
    load_note(8'h11);
    play(1'b1, 4, 0);
    wait_idle();

    // Rest note, then a zero-duration note.
    load_note(8'h03);
    play(1'b1, 12, 0);
    wait_idle();
    load_note(8'h50);
    play(1'b1, 0, 0);
    wait_idle();

    // E2 at tempo 2 (16 cycles, half 4 -> 2 rises); reloads mid-note apply next time.
    load_note(8'hE2);
    load_tempo(8'h02);
    play(1'b1, 16, 2);
    repeat (2) @(negedge clk);
    load_note(8'hA1);
    load_tempo(8'h05);
    wait_idle();
    play(1'b1, 20, 1);
    wait_idle();

    // Reset mid-note: immediate abort, no done pulse, registers restored.
    play(1'b0, 0, 0);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_busy", busy, 1'b0);
    check("midreset_speaker", speaker, 1'b0);
    check("midreset_note_done", note_done, 1'b0);
    reset = 1'b0;
    play(1'b1, 0, 0);
    wait_idle();
    load_note(8'hF1);
    play(1'b1, 4, 1);
    wait_idle();

    // audioact held high: DONE then one IDLE cycle between notes.
    @(negedge clk);
    c0       = cyc;
    audioact = 1'b1;
    s_cont   = 1'b0;
    exp_q.push_back('{c0 + 5,  1});
    exp_q.push_back('{c0 + 11, 1});
    exp_q.push_back('{c0 + 17, 1});
    repeat (17) @(negedge clk);
    audioact = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL outstanding_notes got %0d want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
